// File: rtl/of_pkg.sv
// -----------------------------------------------------------------------------
// of_pkg -- definitions shared by the operand-fetch stage.
//
// Contents:
//   XLEN_DEFAULT  default operand/data width
//   REG_IDX_W     register index width (5 -> 32 architectural registers)
//   REG_X0        index of the hard-wired zero register
//   ofState_t     operand-fetch FSM state encoding
//   isFwdHit()    true when an accepted writeback targets a given source index
// -----------------------------------------------------------------------------
package of_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;

  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a decoded instruction
    READ = 2'd1,  // bank read cycle for rs1/rs2
    CAPT = 2'd2,  // bank data available, operands loaded at end of cycle
    OUT  = 2'd3   // operands presented to the ALU
  } ofState_t;

  // x0 writes never forward: the zero register must stay zero.
  function automatic logic isFwdHit(
    input logic                 wbAccept,
    input logic [REG_IDX_W-1:0] wbRd,
    input logic [REG_IDX_W-1:0] rsIdx
  );
    return wbAccept && (wbRd != REG_X0) && (wbRd == rsIdx);
  endfunction

endpackage

// File: rtl/op_fwd_mux.sv
// -----------------------------------------------------------------------------
// op_fwd_mux -- per-operand source selection.
//
// Picks the value an operand register should load:
//   zero            when the source index is x0 (beats everything else)
//   forwarded data  when a same-cycle writeback targets this source
//   bank data       otherwise
//
// Ports:
//   rsIdx     source register index
//   bankData  data returned by the register bank
//   fwdHit    a writeback to rsIdx is being accepted this cycle
//   fwdData   writeback data
//   opData    selected operand value
// -----------------------------------------------------------------------------
module op_fwd_mux
  import of_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [REG_IDX_W-1:0] rsIdx,
  input  logic [XLEN-1:0]      bankData,
  input  logic                 fwdHit,
  input  logic [XLEN-1:0]      fwdData,
  output logic [XLEN-1:0]      opData
);

  // NOTE: every branch of a combinational block must assign its outputs;
  // a default first avoids inferring a latch when no branch is taken.
  always_comb begin
    opData = bankData;
    if (rsIdx == REG_X0) begin
      opData = '0;
    end else if (fwdHit) begin
      opData = fwdData;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch -- reads rs1/rs2 from a synchronous register bank and hands
// the operands, destination index and control bits to the ALU.
//
// Sequence per instruction: IDLE (handshake) -> READ (bank read) -> CAPT
// (bank data captured into operand registers) -> OUT (held until alu_ready).
// alu_valid is high in the third cycle after the handshake cycle; at most one
// instruction every four cycles.
//
// Writebacks from the ALU stage share the bank port. They are accepted in
// every state except READ (the port is busy reading) and take priority over
// a new instruction in IDLE. A write to x0 is acknowledged but never reaches
// the bank.
//
// Configuration macro:
//   OPERAND_FETCH_FWD_EN  when defined, a writeback accepted in CAPT or OUT
//                         whose rd matches a latched source (not x0) replaces
//                         that operand with the written data.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   dec_*                        decoded instruction handshake and fields
//   alu_*                        operand handshake towards the ALU
//   wb_*                         writeback request from the ALU stage
//   rb_selSrc0/1, rb_selDst      register-bank read/write selectors
//   rb_dst                       register-bank write data
//   rb_RDWRBar, rb_CSBar         bank direction (1=read) and active-low select
//   rb_src0/1                    bank read data, valid the cycle after READ
// -----------------------------------------------------------------------------
module operand_fetch
  import of_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int CTRL_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  // decode side
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic [CTRL_W-1:0]    dec_ctrl,
  // ALU side
  output logic                 alu_valid,
  input  logic                 alu_ready,
  output logic [XLEN-1:0]      alu_op0,
  output logic [XLEN-1:0]      alu_op1,
  output logic [REG_IDX_W-1:0] alu_rd,
  output logic [CTRL_W-1:0]    alu_ctrl,
  // writeback request
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  // register bank
  output logic [REG_IDX_W-1:0] rb_selSrc0,
  output logic [REG_IDX_W-1:0] rb_selSrc1,
  output logic [REG_IDX_W-1:0] rb_selDst,
  output logic [XLEN-1:0]      rb_dst,
  output logic                 rb_RDWRBar,
  output logic                 rb_CSBar,
  input  logic [XLEN-1:0]      rb_src0,
  input  logic [XLEN-1:0]      rb_src1
);

  ofState_t             state;
  logic [REG_IDX_W-1:0] rs1Q;
  logic [REG_IDX_W-1:0] rs2Q;

  logic                 decFire;
  logic                 wbAccept;
  logic                 bankWrite;
  logic                 fwd0;
  logic                 fwd1;
  logic [XLEN-1:0]      op0Next;
  logic [XLEN-1:0]      op1Next;

  // Handshake outputs are gated by reset so no transfer, and in particular
  // no bank write, can happen while reset is asserted.
  assign dec_ready = !reset && (state == IDLE) && !wb_valid;
  assign wb_ready  = !reset && wb_valid && (state != READ);
  assign alu_valid = (state == OUT);

  assign decFire   = dec_valid && dec_ready;
  assign wbAccept  = wb_ready;
  assign bankWrite = wbAccept && (wb_rd != REG_X0);

`ifdef OPERAND_FETCH_FWD_EN
  assign fwd0 = ((state == CAPT) || (state == OUT)) && isFwdHit(wbAccept, wb_rd, rs1Q);
  assign fwd1 = ((state == CAPT) || (state == OUT)) && isFwdHit(wbAccept, wb_rd, rs2Q);
`else
  assign fwd0 = 1'b0;
  assign fwd1 = 1'b0;
`endif

  op_fwd_mux #(.XLEN(XLEN)) u_mux0 (
    .rsIdx    (rs1Q),
    .bankData (rb_src0),
    .fwdHit   (fwd0),
    .fwdData  (wb_data),
    .opData   (op0Next)
  );

  op_fwd_mux #(.XLEN(XLEN)) u_mux1 (
    .rsIdx    (rs2Q),
    .bankData (rb_src1),
    .fwdHit   (fwd1),
    .fwdData  (wb_data),
    .opData   (op1Next)
  );

  // Bank port: READ owns it; otherwise an accepted non-x0 writeback uses it
  // for exactly the acceptance cycle. Idle port: deselected, read direction.
  always_comb begin
    rb_CSBar   = 1'b1;
    rb_RDWRBar = 1'b1;
    rb_selSrc0 = '0;
    rb_selSrc1 = '0;
    rb_selDst  = '0;
    rb_dst     = '0;
    if (state == READ) begin
      rb_CSBar   = 1'b0;
      rb_selSrc0 = rs1Q;
      rb_selSrc1 = rs2Q;
    end else if (bankWrite) begin
      rb_CSBar   = 1'b0;
      rb_RDWRBar = 1'b0;
      rb_selDst  = wb_rd;
      rb_dst     = wb_data;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rs1Q     <= '0;
      rs2Q     <= '0;
      alu_rd   <= '0;
      alu_ctrl <= '0;
      alu_op0  <= '0;
      alu_op1  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (decFire) begin
            rs1Q     <= dec_rs1;
            rs2Q     <= dec_rs2;
            alu_rd   <= dec_rd;
            alu_ctrl <= dec_ctrl;
            state    <= READ;
          end
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          alu_op0 <= op0Next;
          alu_op1 <= op1Next;
          state   <= OUT;
        end
        OUT: begin
          // Operands only change here on a forwarding hit; otherwise they
          // stay stable for the ALU.
          if (fwd0) alu_op0 <= op0Next;
          if (fwd1) alu_op1 <= op1Next;
          if (alu_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch -- directed bench for operand_fetch with a behavioural
// synchronous register bank. Honours OPERAND_FETCH_FWD_EN the same way the
// design does.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [4:0]  dec_rd;
  logic [7:0]  dec_ctrl;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_op0;
  logic [31:0] alu_op1;
  logic [4:0]  alu_rd;
  logic [7:0]  alu_ctrl;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rb_selSrc0;
  logic [4:0]  rb_selSrc1;
  logic [4:0]  rb_selDst;
  logic [31:0] rb_dst;
  logic        rb_RDWRBar;
  logic        rb_CSBar;
  logic [31:0] rb_src0;
  logic [31:0] rb_src1;

  logic [31:0] bankMem [32];

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  operand_fetch #(.XLEN(32), .CTRL_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_rs1    (dec_rs1),
    .dec_rs2    (dec_rs2),
    .dec_rd     (dec_rd),
    .dec_ctrl   (dec_ctrl),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_op0    (alu_op0),
    .alu_op1    (alu_op1),
    .alu_rd     (alu_rd),
    .alu_ctrl   (alu_ctrl),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .rb_selSrc0 (rb_selSrc0),
    .rb_selSrc1 (rb_selSrc1),
    .rb_selDst  (rb_selDst),
    .rb_dst     (rb_dst),
    .rb_RDWRBar (rb_RDWRBar),
    .rb_CSBar   (rb_CSBar),
    .rb_src0    (rb_src0),
    .rb_src1    (rb_src1)
  );

  // Synchronous bank: x0 is ordinary storage here, so the design alone is
  // responsible for returning zero for index 0.
  always @(posedge clk) begin
    if (!rb_CSBar) begin
      if (!rb_RDWRBar) begin
        bankMem[rb_selDst] <= rb_dst;
      end else begin
        rb_src0 <= bankMem[rb_selSrc0];
        rb_src1 <= bankMem[rb_selSrc1];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the handshake edge; counts cycles from the handshake
  // cycle until alu_valid, bounded.
  task automatic waitValid(input string tag);
    int lat;
    dec_valid = 1'b0;
    lat = 1;
    while (!alu_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 3);
  endtask

  task automatic runFetch(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [7:0] ctrl);
    dec_valid = 1'b1;
    dec_rs1   = r1;
    dec_rs2   = r2;
    dec_rd    = rd;
    dec_ctrl  = ctrl;
    #1;
    check({tag, "_dec_ready"}, dec_ready, 1);
    tick();
    waitValid(tag);
  endtask

  task automatic consume(input string tag);
    alu_ready = 1'b1;
    tick();
    alu_ready = 1'b0;
    check({tag, "_valid_drop"}, alu_valid, 0);
    check({tag, "_idle_ready"}, dec_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bankMem[i] = 32'h0;
    bankMem[0] = 32'hDEADBEEF;

    reset     = 1'b1;
    dec_valid = 1'b0;
    dec_rs1   = '0;
    dec_rs2   = '0;
    dec_rd    = '0;
    dec_ctrl  = '0;
    alu_ready = 1'b0;
    // A pending writeback during reset must not be accepted.
    wb_valid  = 1'b1;
    wb_rd     = 5'd3;
    wb_data   = 32'h11111111;

    // ---------------- reset state ----------------
    #2;
    check("rst_alu_valid", alu_valid, 0);
    check("rst_dec_ready", dec_ready, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_csbar", rb_CSBar, 1);
    check("rst_rdwrbar", rb_RDWRBar, 1);
    check("rst_op0", alu_op0, 0);
    check("rst_op1", alu_op1, 0);
    check("rst_rd", alu_rd, 0);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_sel", {rb_selSrc0, rb_selSrc1, rb_selDst}, 0);
    check("rst_dst", rb_dst, 0);
    tick();
    check("rst_no_write", bankMem[3], 32'h0);
    wb_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();

    // ---------------- writeback in IDLE ----------------
    wb_valid = 1'b1;
    wb_rd    = 5'd3;
    wb_data  = 32'hFAEAFAEA;
    #1;
    check("wb3_ready", wb_ready, 1);
    check("wb3_csbar", rb_CSBar, 0);
    check("wb3_rdwrbar", rb_RDWRBar, 0);
    check("wb3_seldst", rb_selDst, 3);
    check("wb3_dst", rb_dst, 32'hFAEAFAEA);
    check("wb3_dec_ready", dec_ready, 0);
    tick();
    wb_rd   = 5'd5;
    wb_data = 32'h00000032;
    #1;
    check("wb5_ready", wb_ready, 1);
    tick();
    wb_rd   = 5'd0;
    wb_data = 32'h00000BAD;
    #1;
    check("wb0_ready", wb_ready, 1);
    check("wb0_csbar", rb_CSBar, 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("idle_csbar", rb_CSBar, 1);
    check("idle_rdwrbar", rb_RDWRBar, 1);
    check("bank_x3", bankMem[3], 32'hFAEAFAEA);
    check("bank_x5", bankMem[5], 32'h00000032);
    check("bank_x0_untouched", bankMem[0], 32'hDEADBEEF);

    // ---------------- basic fetch, cycle by cycle ----------------
    dec_valid = 1'b1;
    dec_rs1   = 5'd3;
    dec_rs2   = 5'd5;
    dec_rd    = 5'd7;
    dec_ctrl  = 8'hA5;
    #1;
    check("f1_dec_ready", dec_ready, 1);
    tick();
    // cycle 1: READ; a writeback arriving now must wait
    dec_valid = 1'b0;
    wb_valid  = 1'b1;
    wb_rd     = 5'd9;
    wb_data   = 32'h00000999;
    #1;
    check("f1_read_csbar", rb_CSBar, 0);
    check("f1_read_rdwrbar", rb_RDWRBar, 1);
    check("f1_read_sel0", rb_selSrc0, 3);
    check("f1_read_sel1", rb_selSrc1, 5);
    check("f1_read_wb_ready", wb_ready, 0);
    check("f1_c1_valid", alu_valid, 0);
    check("f1_read_dec_ready", dec_ready, 0);
    tick();
    // cycle 2: CAPT; the pending writeback goes through
    check("f1_c2_valid", alu_valid, 0);
    check("f1_capt_wb_ready", wb_ready, 1);
    check("f1_capt_rdwrbar", rb_RDWRBar, 0);
    check("f1_capt_seldst", rb_selDst, 9);
    tick();
    wb_valid = 1'b0;
    // cycle 3: OUT
    check("f1_c3_valid", alu_valid, 1);
    check("f1_op0", alu_op0, 32'hFAEAFAEA);
    check("f1_op1", alu_op1, 32'h00000032);
    check("f1_rd", alu_rd, 7);
    check("f1_ctrl", alu_ctrl, 8'hA5);
    check("f1_out_dec_ready", dec_ready, 0);
    check("bank_x9", bankMem[9], 32'h00000999);
    tick();
    check("f1_hold_valid", alu_valid, 1);
    check("f1_hold_op0", alu_op0, 32'hFAEAFAEA);
    consume("f1");

    // ---------------- rs1 = x0 reads zero ----------------
    runFetch("x0", 5'd0, 5'd3, 5'd4, 8'h3C);
    check("x0_op0", alu_op0, 32'h0);
    check("x0_op1", alu_op1, 32'hFAEAFAEA);
    check("x0_rd", alu_rd, 4);
    consume("x0");

    // ---------------- write beats decode in IDLE ----------------
    wb_valid  = 1'b1;
    wb_rd     = 5'd4;
    wb_data   = 32'h44444444;
    dec_valid = 1'b1;
    dec_rs1   = 5'd4;
    dec_rs2   = 5'd0;
    dec_rd    = 5'd1;
    dec_ctrl  = 8'h0F;
    #1;
    check("col_dec_ready", dec_ready, 0);
    check("col_wb_ready", wb_ready, 1);
    check("col_csbar", rb_CSBar, 0);
    check("col_rdwrbar", rb_RDWRBar, 0);
    check("col_seldst", rb_selDst, 4);
    tick();
    wb_valid = 1'b0;
    #1;
    check("col_dec_ready_next", dec_ready, 1);
    tick();
    waitValid("col");
    check("col_op0", alu_op0, 32'h44444444);
    check("col_op1", alu_op1, 32'h0);
    check("col_rd", alu_rd, 1);
    consume("col");

    // ---------------- writeback to rs2 while stalled in OUT ----------------
    runFetch("fwd", 5'd3, 5'd5, 5'd2, 8'h55);
    check("fwd_op1_before", alu_op1, 32'h00000032);
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    wb_data  = 32'h00001234;
    #1;
    check("fwd_wb_ready", wb_ready, 1);
    tick();
    wb_valid = 1'b0;
    check("fwd_valid_held", alu_valid, 1);
`ifdef OPERAND_FETCH_FWD_EN
    check("fwd_op1_after", alu_op1, 32'h00001234);
`else
    check("fwd_op1_after", alu_op1, 32'h00000032);
`endif
    check("fwd_op0_after", alu_op0, 32'hFAEAFAEA);
    check("bank_x5_new", bankMem[5], 32'h00001234);
    consume("fwd");

    // ---------------- reset while in OUT ----------------
    runFetch("mid", 5'd3, 5'd5, 5'd6, 8'h77);
    wb_valid = 1'b1;
    wb_rd    = 5'd8;
    wb_data  = 32'h00008888;
    reset    = 1'b1;
    #1;
    check("mid_valid", alu_valid, 0);
    check("mid_csbar", rb_CSBar, 1);
    check("mid_wb_ready", wb_ready, 0);
    check("mid_dec_ready", dec_ready, 0);
    check("mid_op0", alu_op0, 32'h0);
    check("mid_rd", alu_rd, 0);
    tick();
    check("mid_no_write", bankMem[8], 32'h0);
    wb_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_valid", alu_valid, 0);
    check("post_dec_ready", dec_ready, 1);
    runFetch("post", 5'd5, 5'd3, 5'd11, 8'hC3);
    check("post_op0", alu_op0, 32'h00001234);
    check("post_op1", alu_op1, 32'hFAEAFAEA);
    check("post_rd", alu_rd, 11);
    check("post_ctrl", alu_ctrl, 8'hC3);
    consume("post");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32, operand/data width.
REQ-002 Parameter CTRL_W, default 8, width of opaque decode-control passthrough.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 dec_valid  input  1  decoded instruction available.
REQ-006 dec_ready  output  1  block accepts instruction this cycle.
REQ-007 dec_rs1, dec_rs2, dec_rd  input  5 each  source/destination register indices.
REQ-008 dec_ctrl  input  CTRL_W  control bits carried to ALU unchanged.
REQ-009 alu_valid  output  1  operands valid for ALU.
REQ-010 alu_ready  input  1  ALU consumes operands.
REQ-011 alu_op0, alu_op1  output  XLEN each  operands for rs1, rs2.
REQ-012 alu_rd  output  5; alu_ctrl  output  CTRL_W  latched dec_rd and dec_ctrl.
REQ-013 wb_valid  input  1; wb_ready  output  1; wb_rd  input  5; wb_data  input  XLEN  writeback request from ALU stage.
REQ-014 rb_selSrc0, rb_selSrc1, rb_selDst  output  5 each  register-bank selectors.
REQ-015 rb_dst  output  XLEN  register-bank write data.
REQ-016 rb_RDWRBar  output  1  1=read, 0=write; rb_CSBar  output  1  active-low bank select.
REQ-017 rb_src0, rb_src1  input  XLEN  register-bank read data, registered by bank on the edge ending a read cycle.

Function
REQ-018 FSM states SHALL be IDLE, READ, CAPT, OUT.
REQ-019 IDLE: dec_ready = !wb_valid; dec handshake latches rs1/rs2/rd/ctrl and moves to READ.
REQ-020 READ (1 cycle): rb_CSBar=0, rb_RDWRBar=1, rb_selSrc0=rs1, rb_selSrc1=rs2; wb_ready=0; next CAPT.
REQ-021 CAPT (1 cycle): operand registers load rb_src0/rb_src1; next OUT.
REQ-022 OUT: alu_valid=1, outputs held stable until alu_ready; on alu_ready next state IDLE.
REQ-023 Latency: alu_valid asserts exactly 3 cycles after the dec handshake edge; throughput one instruction per 4 cycles minimum.
REQ-024 Writeback accepted (wb_ready=1 when wb_valid) in IDLE, CAPT, OUT; write drives rb_CSBar=0, rb_RDWRBar=0, rb_selDst=wb_rd, rb_dst=wb_data for that cycle only.
REQ-025 Simultaneous wb_valid and dec_valid in IDLE: write wins; dec_ready=0 that cycle.
REQ-026 wb_rd=0: handshake completes, bank not selected (rb_CSBar=1).
REQ-027 rs index 0: corresponding operand SHALL be 0 regardless of rb_src data.
REQ-028 No bank access cycle: rb_CSBar=1, rb_RDWRBar=1.

Reset
REQ-029 Reset asserted: state IDLE; alu_valid=0, dec_ready=0, wb_ready=0, alu_op0/alu_op1/alu_rd/alu_ctrl=0, rb_CSBar=1, rb_RDWRBar=1, selectors and rb_dst=0.
REQ-030 Reset mid-operation discards the in-flight instruction; no bank write completes after reset asserts.

Configuration
REQ-031 Macro OPERAND_FETCH_FWD_EN defined: accepted write in CAPT or OUT with wb_rd!=0 matching latched rs1/rs2 SHALL replace the matching operand with wb_data (CAPT: instead of rb_src; OUT: next cycle).
REQ-032 Macro undefined: no forwarding; operands reflect bank values read in READ.

Structure
REQ-033 Shared package of_pkg SHALL hold the FSM state enum, XLEN default, REG_IDX_W=5, REG_X0=0.
REQ-034 One sub-module op_fwd_mux SHALL select per-operand among zero, bank data, forwarded data.

Verification
REQ-035 After reset, wb_rd=3, wb_data=FAEAFAEA in IDLE -> one cycle rb_CSBar=0, rb_RDWRBar=0, rb_selDst=3, rb_dst=FAEAFAEA, wb_ready=1.
REQ-036 Bank x3=FAEAFAEA, x5=00000032; dec rs1=3, rs2=5, rd=7 -> alu_valid 3 cycles later, alu_op0=FAEAFAEA, alu_op1=00000032, alu_rd=7.
REQ-037 rs1=0 with bank model returning DEADBEEF -> alu_op0=00000000.
REQ-038 wb_valid and dec_valid same IDLE cycle -> write issued, dec_ready=0; instruction accepted next cycle.
REQ-039 rs2=5, alu_ready=0 in OUT, write rd=5 data 00001234 -> with OPERAND_FETCH_FWD_EN alu_op1=00001234 next cycle; without, stays 00000032.
REQ-040 Reset asserted in OUT -> alu_valid=0 and rb_CSBar=1 immediately, state IDLE after release.
